// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK burst scheduler and the modulator that
// consumes its sym_en / sym_bit outputs.
package bpsk_pkg;

  localparam int WORD_W     = 32;
  localparam int DIV_FACTOR = 544;
  localparam int REPEAT     = 4;
  localparam int GAP_SYMS   = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Bits needed to hold 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sym_rate_gen.sv
// Free-running symbol-rate divider: counts 0..DIV_FACTOR-1 and flags the
// last clock of every symbol period.
module sym_rate_gen #(
  parameter int DIV_FACTOR = bpsk_pkg::DIV_FACTOR
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sym_tick
);
  import bpsk_pkg::*;

  localparam int               CNT_W    = cnt_w(DIV_FACTOR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_FACTOR - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Gated by reset so a one-cycle divider cannot tick while held in reset.
  assign o_sym_tick = i_rst_n && (r_cnt == CNT_LAST);

endmodule

// File: rtl/bpsk_burst_sched.sv
// Two-requester BPSK burst scheduler: accepts a 32-bit word, sends it REPEAT
// times MSB first at the symbol rate, then stays silent for GAP_SYMS symbols.
module bpsk_burst_sched #(
  parameter int DIV_FACTOR = bpsk_pkg::DIV_FACTOR,
  parameter int REPEAT     = bpsk_pkg::REPEAT,
  parameter int GAP_SYMS   = bpsk_pkg::GAP_SYMS
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        sym_tick,
  output logic        sym_en,
  output logic        sym_bit,
  output logic        busy,
  output logic        grant_id,
  output logic        burst_done
);
  import bpsk_pkg::*;

  localparam int               BIT_W    = cnt_w(WORD_W - 1);
  localparam int               REP_W    = cnt_w(REPEAT - 1);
  localparam int               GAP_W    = cnt_w(GAP_SYMS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_SYMS - 1);

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_word;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [REP_W-1:0]  r_rep;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_last_grant;
  logic              r_grant_id;
  logic              r_sym_en;
  logic              r_sym_bit;
  logic              r_burst_done;

  logic              w_tick;
  logic              w_idle;
  logic              w_sel;
  logic              w_ready0;
  logic              w_ready1;
  logic [BIT_W-1:0]  w_bit_nxt;

  sym_rate_gen #(
    .DIV_FACTOR(DIV_FACTOR)
  ) u_sym_rate_gen (
    .i_clk      (clk_in),
    .i_rst_n    (rst_n),
    .o_sym_tick (w_tick)
  );

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_idle    = rst_n && (r_state == ST_IDLE);
  assign w_ready0  = w_idle && req0_valid && !w_sel;
  assign w_ready1  = w_idle && req1_valid &&  w_sel;
  assign w_bit_nxt = (r_bit_idx == BIT_LAST) ? '0 : r_bit_idx + BIT_W'(1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_bit_idx    <= '0;
      r_rep        <= '0;
      r_gap_cnt    <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_sym_en     <= 1'b0;
      r_sym_bit    <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ready0 || w_ready1) begin
            r_word       <= w_sel ? req1_data : req0_data;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_state      <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_tick) begin
            r_state   <= ST_SEND;
            r_bit_idx <= '0;
            r_rep     <= '0;
            r_sym_en  <= 1'b1;
            r_sym_bit <= r_word[WORD_W-1];
          end
        end
        ST_SEND: begin
          if (w_tick) begin
            r_bit_idx <= w_bit_nxt;
            r_sym_bit <= r_word[BIT_LAST - w_bit_nxt];
            if (r_bit_idx == BIT_LAST) begin
              if (r_rep == REP_LAST) begin
                r_state   <= ST_GAP;
                r_rep     <= '0;
                r_gap_cnt <= '0;
                r_sym_en  <= 1'b0;
                r_sym_bit <= 1'b0;
              end else begin
                r_rep <= r_rep + REP_W'(1);
              end
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt    <= '0;
              r_state      <= ST_IDLE;
              r_burst_done <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign sym_tick   = w_tick;
  assign sym_en     = r_sym_en;
  assign sym_bit    = r_sym_bit;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_grant_id;
  assign burst_done = r_burst_done;

endmodule
